hdmi_period_sequencer: RTL and testbench

HDMI_PERIOD_SEQUENCER -- requirements
Module: hdmi_period_sequencer

---
 rtl/hdmi_period_sequencer_if.sv | 31 +++
 rtl/hdmi_period_sequencer.sv | 131 +++++++++++++
 tb/tb_hdmi_period_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_period_sequencer_if.sv
// Video-in / encoder-out bundle for the HDMI period sequencer.
// master drives raw timing, slave (the sequencer) returns encoder controls.
interface hdmi_period_sequencer_if;
    logic        pixel_stb;
    logic        hdmi_en;
    logic        de_in;
    logic        hs_in;
    logic        vs_in;
    logic [23:0] rgb_in;
    logic        pixel_stb_out;
    logic        enc_window;
    logic        enc_guard;
    logic [7:0]  enc_d0;
    logic [7:0]  enc_d1;
    logic [7:0]  enc_d2;
    logic [2:0]  enc_c0;
    logic [2:0]  enc_c1;
    logic        short_blank_err;

    modport master (
        output pixel_stb, hdmi_en, de_in, hs_in, vs_in, rgb_in,
        input  pixel_stb_out, enc_window, enc_guard,
        input  enc_d0, enc_d1, enc_d2, enc_c0, enc_c1, short_blank_err
    );

    modport slave (
        input  pixel_stb, hdmi_en, de_in, hs_in, vs_in, rgb_in,
        output pixel_stb_out, enc_window, enc_guard,
        output enc_d0, enc_d1, enc_d2, enc_c0, enc_c1, short_blank_err
    );
endinterface

// File: rtl/hdmi_period_sequencer.sv
// Delays video by LEAD pixel slots so the preamble and leading guard band
// can be inserted ahead of each active-video period.
module hdmi_period_sequencer #(
    parameter int PREAMBLE_LEN = 8,
    parameter int GUARD_LEN    = 2
) (
    input logic                     clk,
    input logic                     reset,
    hdmi_period_sequencer_if.slave  io
);
    localparam int LEAD = PREAMBLE_LEN + GUARD_LEN;
    localparam logic [3:0] PRE_N = 4'(PREAMBLE_LEN);
    localparam logic [3:0] GRD_N = 4'(GUARD_LEN);

    typedef enum logic [1:0] {CTRL, PREAMBLE, GUARD, VIDEO} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, cnt_inc;
    logic        prev_de_q, prev_de_d;
    logic [26:0] dl_q [LEAD];
    logic [26:0] dl_d [LEAD];
    logic        err_q, err_d;
    logic        stb_q, stb_d;
    logic        win_q, win_d;
    logic        grd_q, grd_d;
    logic [23:0] rgb_q, rgb_d;
    logic [2:0]  c0_q, c0_d;
    logic [2:0]  c1_q, c1_d;
    logic        dly_de, dly_hs, dly_vs, rise;
    logic [23:0] dly_rgb;

    assign dly_de  = dl_q[LEAD-1][26];
    assign dly_hs  = dl_q[LEAD-1][25];
    assign dly_vs  = dl_q[LEAD-1][24];
    assign dly_rgb = dl_q[LEAD-1][23:0];
    assign rise    = io.de_in & ~prev_de_q;
    assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prev_de_d = prev_de_q;
        dl_d      = dl_q;
        err_d     = err_q;
        stb_d     = io.pixel_stb;
        win_d     = win_q;
        grd_d     = grd_q;
        rgb_d     = rgb_q;
        c0_d      = c0_q;
        c1_d      = c1_q;
        if (io.pixel_stb) begin
            prev_de_d = io.de_in;
            dl_d[0]   = {io.de_in, io.hs_in, io.vs_in, io.rgb_in};
            for (int i = 1; i < LEAD; i++) dl_d[i] = dl_q[i-1];
            unique case (state_q)
                CTRL: begin
                    // A delayed run with no preamble in HDMI mode stays control.
                    if (io.hdmi_en && rise) begin
                        state_d = PREAMBLE;
                        cnt_d   = 4'd1;
                    end else if (!io.hdmi_en && dly_de) begin
                        state_d = VIDEO;
                    end
                end
                PREAMBLE: begin
                    if (cnt_q == PRE_N) begin
                        state_d = GUARD;
                        cnt_d   = 4'd1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                GUARD: begin
                    if (cnt_q == GRD_N) begin
                        state_d = dly_de ? VIDEO : CTRL;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                VIDEO: begin
                    if (rise) err_d = 1'b1;
                    if (!dly_de) state_d = CTRL;
                end
            endcase
            win_d = (state_d == VIDEO) && dly_de;
            grd_d = (state_d == GUARD);
            rgb_d = dly_rgb;
            c0_d  = {1'b0, state_d == PREAMBLE, dly_hs & ~grd_d};
            c1_d  = {2'b00, dly_vs & ~grd_d};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CTRL;
            cnt_q     <= 4'd0;
            prev_de_q <= 1'b0;
            for (int i = 0; i < LEAD; i++) dl_q[i] <= 27'd0;
            err_q     <= 1'b0;
            stb_q     <= 1'b0;
            win_q     <= 1'b0;
            grd_q     <= 1'b0;
            rgb_q     <= 24'd0;
            c0_q      <= 3'd0;
            c1_q      <= 3'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_de_q <= prev_de_d;
            dl_q      <= dl_d;
            err_q     <= err_d;
            stb_q     <= stb_d;
            win_q     <= win_d;
            grd_q     <= grd_d;
            rgb_q     <= rgb_d;
            c0_q      <= c0_d;
            c1_q      <= c1_d;
        end
    end

    assign io.pixel_stb_out   = stb_q;
    assign io.enc_window      = win_q;
    assign io.enc_guard       = grd_q;
    assign io.enc_d0          = rgb_q[7:0];
    assign io.enc_d1          = rgb_q[15:8];
    assign io.enc_d2          = rgb_q[23:16];
    assign io.enc_c0          = c0_q;
    assign io.enc_c1          = c1_q;
    assign io.short_blank_err = err_q;
endmodule

// File: tb/tb_hdmi_period_sequencer.sv
// Bench for hdmi_period_sequencer: vector table, directed sequences and
// random traffic against a slot-level reference model.
module tb_hdmi_period_sequencer;
    localparam int P    = 8;
    localparam int G    = 2;
    localparam int LEAD = P + G;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hdmi_period_sequencer_if bus ();

    hdmi_period_sequencer #(.PREAMBLE_LEN(P), .GUARD_LEN(G)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Model: phase -1 = control, 0..LEAD-1 = position in preamble+guard,
    // LEAD = active video.
    int          phase;
    bit          m_prev;
    bit          m_err;
    logic [26:0] hist [$];
    logic [31:0] m_vis;
    bit          m_stb;

    int cnt_pre, cnt_grd, cnt_win, cnt_cx, first_win, slot_no, rise_no;
    logic [23:0] first_d;
    int act_idx;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
        end
    endtask

    function automatic logic [33:0] act_out();
        return {bus.pixel_stb_out, bus.enc_window, bus.enc_guard,
                bus.enc_c0, bus.enc_c1, bus.enc_d2, bus.enc_d1, bus.enc_d0,
                bus.short_blank_err};
    endfunction

    task automatic model_reset();
        phase  = -1;
        m_prev = 1'b0;
        m_err  = 1'b0;
        m_vis  = '0;
        hist.delete();
        repeat (LEAD) hist.push_back(27'd0);
    endtask

    task automatic model_strobe(input bit de, hs, vs, en, input logic [23:0] rgb);
        logic [26:0] dly;
        bit rise, win, grd, pre;
        dly = hist.pop_front();
        hist.push_back({de, hs, vs, rgb});
        rise   = de && !m_prev;
        m_prev = de;
        if (phase == LEAD && rise) m_err = 1'b1;
        if (phase < 0) begin
            if (en && rise) phase = 0;
            else if (!en && dly[26]) phase = LEAD;
        end else if (phase < LEAD) begin
            phase++;
            if (phase == LEAD && !dly[26]) phase = -1;
        end else if (!dly[26]) begin
            phase = -1;
        end
        win = (phase == LEAD);
        grd = (phase >= P) && (phase < LEAD);
        pre = (phase >= 0) && (phase < P);
        m_vis = {win, grd, 1'b0, pre, dly[25] & !grd, 2'b00, dly[24] & !grd, dly[23:0]};
    endtask

    task automatic cyc(input bit r, stb, en, de, hs, vs, input logic [23:0] rgb);
        @(negedge clk);
        reset         = r;
        bus.pixel_stb = stb;
        bus.hdmi_en   = en;
        bus.de_in     = de;
        bus.hs_in     = hs;
        bus.vs_in     = vs;
        bus.rgb_in    = rgb;
        @(posedge clk);
        if (r) model_reset();
        else if (stb) model_strobe(de, hs, vs, en, rgb);
        m_stb = r ? 1'b0 : stb;
        #1;
        chk("outputs", {30'd0, act_out()}, {30'd0, m_stb, m_vis[31:24], m_vis[23:0], m_err});
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
    endtask

    task automatic slot(input int per, input bit en, input bit de);
        logic [23:0] px;
        px = de ? 24'h5A0000 + 24'(act_idx) : 24'($urandom);
        repeat (per - 1) cyc(1'b0, 1'b0, en, de, 1'($urandom), 1'($urandom), px);
        cyc(1'b0, 1'b1, en, de, 1'($urandom), 1'($urandom), px);
        if (de) act_idx++;
        if (bus.enc_c0[1]) cnt_pre++;
        if (bus.enc_guard) cnt_grd++;
        if (bus.enc_c0[2] || bus.enc_c1[2] || bus.enc_c1[1]) cnt_cx++;
        if (bus.enc_window) begin
            cnt_win++;
            if (first_win < 0) begin
                first_win = slot_no - rise_no;
                first_d   = {bus.enc_d2, bus.enc_d1, bus.enc_d0};
            end
        end
        slot_no++;
    endtask

    task automatic seq(input int per, input bit en, input int b0, a0, b1, a1, tl);
        cnt_pre = 0; cnt_grd = 0; cnt_win = 0; cnt_cx = 0;
        first_win = -1; slot_no = 0; act_idx = 0;
        repeat (b0) slot(per, en, 1'b0);
        rise_no = slot_no;
        repeat (a0) slot(per, en, 1'b1);
        repeat (b1) slot(per, en, 1'b0);
        repeat (a1) slot(per, en, 1'b1);
        repeat (tl) slot(per, en, 1'b0);
    endtask

    typedef struct {
        bit r, stb, en, de, hs, vs;
        bit win, grd;
        logic [2:0] c0, c1;
    } vec_t;

    vec_t tbl [10];

    initial begin
        bit de_r, en_r, stb_r, r_r;
        int run;
        tbl[0] = '{1, 0, 1, 0, 0, 0, 0, 0, 3'b000, 3'b000};
        tbl[1] = '{0, 1, 1, 0, 1, 1, 0, 0, 3'b000, 3'b000};
        tbl[2] = '{0, 1, 1, 1, 1, 1, 0, 0, 3'b010, 3'b000};
        tbl[3] = '{0, 0, 1, 1, 0, 0, 0, 0, 3'b010, 3'b000};
        tbl[4] = '{0, 1, 1, 1, 0, 0, 0, 0, 3'b010, 3'b000};
        tbl[5] = '{1, 1, 1, 1, 0, 0, 0, 0, 3'b000, 3'b000};
        tbl[6] = '{0, 1, 1, 1, 0, 1, 0, 0, 3'b010, 3'b000};
        tbl[7] = '{0, 1, 1, 0, 1, 0, 0, 0, 3'b010, 3'b000};
        tbl[8] = '{0, 1, 0, 0, 1, 1, 0, 0, 3'b010, 3'b000};
        tbl[9] = '{1, 0, 1, 0, 0, 0, 0, 0, 3'b000, 3'b000};

        model_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].r, tbl[i].stb, tbl[i].en, tbl[i].de, tbl[i].hs, tbl[i].vs, 24'h123456);
            chk($sformatf("vec%0d", i),
                {56'd0, bus.enc_window, bus.enc_guard, bus.enc_c0, bus.enc_c1},
                {56'd0, tbl[i].win, tbl[i].grd, tbl[i].c0, tbl[i].c1});
        end

        do_reset();
        seq(1, 1'b1, 100, 16, 0, 0, 20);
        chk("hdmi_pre", 64'(cnt_pre), 64'(P));
        chk("hdmi_grd", 64'(cnt_grd), 64'(G));
        chk("hdmi_win", 64'(cnt_win), 64'd16);
        chk("hdmi_lat", 64'(first_win), 64'(LEAD));
        chk("hdmi_px0", 64'(first_d), 64'h5A0000);

        do_reset();
        seq(4, 1'b1, 30, 16, 0, 0, 20);
        chk("slow_pre", 64'(cnt_pre), 64'(P));
        chk("slow_grd", 64'(cnt_grd), 64'(G));
        chk("slow_lat", 64'(first_win), 64'(LEAD));

        do_reset();
        seq(1, 1'b0, 30, 16, 0, 0, 20);
        chk("dvi_pre", 64'(cnt_pre + cnt_grd), 64'd0);
        chk("dvi_cx", 64'(cnt_cx), 64'd0);
        chk("dvi_win", 64'(cnt_win), 64'd16);
        chk("dvi_lat", 64'(first_win), 64'(LEAD));

        do_reset();
        seq(1, 1'b1, 30, 20, 5, 20, 20);
        chk("short_pre", 64'(cnt_pre), 64'(P));
        chk("short_err", 64'(bus.short_blank_err), 64'd1);
        repeat (15) slot(1, 1'b1, 1'b0);
        chk("err_sticky", 64'(bus.short_blank_err), 64'd1);
        do_reset();
        chk("err_clear", 64'(bus.short_blank_err), 64'd0);

        seq(1, 1'b1, 30, 3, 0, 0, 20);
        chk("run3_pre", 64'(cnt_pre), 64'(P));
        chk("run3_grd", 64'(cnt_grd), 64'(G));
        chk("run3_win", 64'(cnt_win), 64'd3);

        do_reset();
        seq(1, 1'b1, 20, 5, 0, 0, 0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 24'hFFFFFF);
        chk("rst_mid", {30'd0, act_out()}, 64'd0);
        seq(1, 1'b1, 20, 16, 0, 0, 20);
        chk("rst_pre", 64'(cnt_pre), 64'(P));
        chk("rst_win", 64'(cnt_win), 64'd16);

        do_reset();
        de_r = 1'b0;
        en_r = 1'b1;
        run  = 5;
        for (int i = 0; i < 4000; i++) begin
            stb_r = ($urandom % 3) != 0;
            r_r   = ($urandom % 700) == 0;
            if (stb_r) begin
                if (run == 0) begin
                    de_r = !de_r;
                    run  = ($urandom % 4 == 0) ? int'($urandom_range(1, 6))
                                               : int'($urandom_range(1, 25));
                end
                run--;
            end
            if ($urandom % 60 == 0) en_r = !en_r;
            cyc(r_r, stb_r, en_r, de_r, 1'($urandom), 1'($urandom), 24'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
